// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
// Optional parity support is selected with the SERIAL_RX_PARITY_EN macro.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } rx_state_t;

    // XOR over data plus parity bit must equal this value for a clean frame.
    localparam logic EVEN_PARITY = 1'b0;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_parallel_receiver_core.sv
// Shift register and bit counter for the serial receiver.
// o_word shows the register contents as they will be after this edge.
module rx_shift_core
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_shift,
    input  logic                    i_start,
    input  logic                    i_serI,
    input  logic                    i_clear,
    output logic [WIDTH-1:0]        o_word,
    output logic [cnt_w(WIDTH)-1:0] o_count
);

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;

    // A frame start discards whatever partial word was sitting in the register.
    assign w_base = i_start ? '0 : r_shift;

    if (MSB_FIRST) begin : g_msb
        assign w_next = {w_base[WIDTH-2:0], i_serI};
    end else begin : g_lsb
        assign w_next = {i_serI, w_base[WIDTH-1:1]};
    end

    assign o_word  = i_shift ? w_next : r_shift;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else begin
            if (i_shift) begin
                r_shift <= w_next;
            end
            if (i_clear) begin
                r_count <= '0;
            end else if (i_start) begin
                r_count <= i_shift ? CW'(1) : '0;
            end else if (i_shift) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_parallel_receiver.sv
// Serial link receiver: frames WIDTH-bit words into a one-word holding register
// with Valid/Ready handshake and overrun flag. Parity via SERIAL_RX_PARITY_EN.
module serial_parallel_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SerI,
    input  logic             Shift,
    input  logic             Start,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    input  logic             Ready,
    output logic             Busy,
    output logic             Overrun,
    input  logic             ClrOvr,
    output logic             ParErr
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        r_state;
    rx_state_t        w_nextState;
    logic             w_dataShift;
    logic             w_complete;
    logic             w_parErr;
    logic             w_drop;
    logic [WIDTH-1:0] w_word;
    logic [CW-1:0]    w_count;

    rx_shift_core #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_shift(w_dataShift),
        .i_start(Start),
        .i_serI (SerI),
        .i_clear(w_complete),
        .o_word (w_word),
        .o_count(w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Start overrides everything; data bits only count while a frame is open.
    always_comb begin
        w_nextState = r_state;
        w_complete  = 1'b0;
        w_parErr    = 1'b0;
        w_dataShift = Shift && (Start || (r_state == RECV));
        if (Start) begin
            w_nextState = RECV;
        end else begin
            case (r_state)
                RECV: begin
                    if (Shift && (w_count == LAST)) begin
`ifdef SERIAL_RX_PARITY_EN
                        w_nextState = PAR;
`else
                        w_nextState = IDLE;
                        w_complete  = 1'b1;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PAR: begin
                    if (Shift) begin
                        w_nextState = IDLE;
                        w_complete  = 1'b1;
                        w_parErr    = ((^w_word) ^ SerI) != EVEN_PARITY;
                    end
                end
`endif
                default: w_nextState = IDLE;
            endcase
        end
    end

    assign w_drop = w_complete && Valid && !Ready;
    assign Busy   = (r_state != IDLE);

    // A word arriving while the previous one is still unread is thrown away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q       <= '0;
            Valid   <= 1'b0;
            ParErr  <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (w_drop) begin
                Overrun <= 1'b1;
            end else if (ClrOvr) begin
                Overrun <= 1'b0;
            end
            if (w_complete && !w_drop) begin
                Q      <= w_word;
                Valid  <= 1'b1;
                ParErr <= w_parErr;
            end else if (Valid && Ready) begin
                Valid  <= 1'b0;
                ParErr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_parallel_receiver.sv
// Bench for serial_parallel_receiver: MSB-first and LSB-first instances share
// stimulus and are checked each cycle against a bit-queue model of the link.
module tb_serial_parallel_receiver;

    localparam int WIDTH = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serI = 1'b0;
    logic shift = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic clrOvr = 1'b0;

    logic [WIDTH-1:0] qA, qB;
    logic validA, validB, busyA, busyB, ovrA, ovrB, perrA, perrB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_parallel_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst_n(rst_n), .SerI(serI), .Shift(shift), .Start(start),
        .Q(qA), .Valid(validA), .Ready(ready), .Busy(busyA),
        .Overrun(ovrA), .ClrOvr(clrOvr), .ParErr(perrA)
    );

    serial_parallel_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst_n(rst_n), .SerI(serI), .Shift(shift), .Start(start),
        .Q(qB), .Valid(validB), .Ready(ready), .Busy(busyB),
        .Overrun(ovrB), .ClrOvr(clrOvr), .ParErr(perrB)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: collect received bits in a queue and build words from them.
    bit         mBits[$];
    bit         mInFrame = 1'b0;
    logic [3:0] mQa = '0;
    logic [3:0] mQb = '0;
    bit         mVld = 1'b0;
    bit         mPe = 1'b0;
    bit         mOvr = 1'b0;
    bit         mComplete, mDropped, mPar;
    logic [3:0] mWa, mWb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBits.delete();
            mInFrame = 1'b0;
            mQa = '0;
            mQb = '0;
            mVld = 1'b0;
            mPe = 1'b0;
            mOvr = 1'b0;
        end else begin
            mComplete = 1'b0;
            mDropped = 1'b0;
            mWa = '0;
            mWb = '0;
            mPar = 1'b0;
            if (start) begin
                mBits.delete();
                mInFrame = 1'b1;
                if (shift) mBits.push_back(serI);
            end else if (mInFrame && shift) begin
                mBits.push_back(serI);
            end
            if (mBits.size() == NB) begin
                mComplete = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    mWa[WIDTH-1-i] = mBits[i];
                    mWb[i] = mBits[i];
                end
`ifdef SERIAL_RX_PARITY_EN
                for (int i = 0; i < NB; i++) mPar = mPar ^ mBits[i];
`endif
                mBits.delete();
                mInFrame = 1'b0;
            end
            if (mComplete && mVld && !ready) begin
                mDropped = 1'b1;
            end else if (mComplete) begin
                mQa = mWa;
                mQb = mWb;
                mVld = 1'b1;
                mPe = mPar;
            end else if (mVld && ready) begin
                mVld = 1'b0;
                mPe = 1'b0;
            end
            if (mDropped) mOvr = 1'b1;
            else if (clrOvr) mOvr = 1'b0;
        end
    end

    always @(negedge clk) begin
        checkOutput("qMsb", qA, mQa);
        checkOutput("qLsb", qB, mQb);
        checkOutput("validMsb", validA, mVld);
        checkOutput("validLsb", validB, mVld);
        checkOutput("busyMsb", busyA, mInFrame);
        checkOutput("busyLsb", busyB, mInFrame);
        checkOutput("overrunMsb", ovrA, mOvr);
        checkOutput("overrunLsb", ovrB, mOvr);
        checkOutput("parErrMsb", perrA, mPe);
        checkOutput("parErrLsb", perrB, mPe);
    end

    task automatic applyStimulus(input logic st, input logic sh, input logic sd,
                                 input logic rdy, input logic clr);
        start = st;
        shift = sh;
        serI = sd;
        ready = rdy;
        clrOvr = clr;
        @(posedge clk);
        #1;
    endtask

    // Bits go out in the order written (d[3] first); parity bit only when enabled.
    task automatic sendFrame(input logic [3:0] d, input logic parBit,
                             input logic rdyBody, input logic rdyLast);
        logic b;
        for (int i = 0; i < NB; i++) begin
            b = (i < WIDTH) ? d[3-i] : parBit;
            applyStimulus(i == 0, 1'b1, b, (i == NB - 1) ? rdyLast : rdyBody, 1'b0);
        end
    endtask

    logic [3:0] frm;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetQ", qA, 4'b0000);
        checkOutput("resetValid", validA, 1'b0);
        checkOutput("resetBusy", busyA, 1'b0);
        checkOutput("resetOverrun", ovrA, 1'b0);
        checkOutput("resetParErr", perrA, 1'b0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        frm = 4'b1011;
        sendFrame(frm, ^frm, 1'b1, 1'b1);
        checkOutput("t1QMsb", qA, 4'b1011);
        checkOutput("t2QLsb", qB, 4'b1101);
        checkOutput("t1Valid", validA, 1'b1);
        checkOutput("t1BusyDone", busyA, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t1ValidCleared", validA, 1'b0);
        checkOutput("t1QHeld", qA, 4'b1011);

        sendFrame(frm, ^frm, 1'b0, 1'b0);
        frm = 4'b0011;
        sendFrame(frm, ^frm, 1'b0, 1'b0);
        checkOutput("t3QKept", qA, 4'b1011);
        checkOutput("t3Overrun", ovrA, 1'b1);
        checkOutput("t3ValidKept", validA, 1'b1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t3OverrunCleared", ovrA, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);

        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("t4BusyFirstBit", busyA, 1'b1);
        applyStimulus(0, 1, 0, 0, 0);
        sendFrame(frm, ^frm, 1'b0, 1'b0);
        checkOutput("t4Q", qA, 4'b0011);
        checkOutput("t4NoOverrun", ovrA, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);

        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(0, 1, 1, 1, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5AsyncQ", qA, 4'b0000);
        checkOutput("t5AsyncBusy", busyA, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frm = 4'b1011;
        sendFrame(frm, ^frm, 1'b1, 1'b1);
        checkOutput("t5QAfterReset", qA, 4'b1011);
        applyStimulus(0, 0, 0, 1, 0);

        frm = 4'b0110;
        sendFrame(frm, ^frm, 1'b0, 1'b0);
        frm = 4'b1001;
        sendFrame(frm, ^frm, 1'b0, 1'b1);
        checkOutput("handoverQ", qA, 4'b1001);
        checkOutput("handoverValid", validA, 1'b1);
        checkOutput("handoverNoOverrun", ovrA, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);

`ifdef SERIAL_RX_PARITY_EN
        frm = 4'b1011;
        sendFrame(frm, 1'b1, 1'b0, 1'b0);
        checkOutput("t6ParityGood", perrA, 1'b0);
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(frm, 1'b0, 1'b0, 1'b0);
        checkOutput("t6ParityBad", perrA, 1'b1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6ParErrConsumed", perrA, 1'b0);
`endif

        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0,
                          1'($urandom_range(0, 1)),
                          (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 20) == 0);
        end

        applyStimulus(0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
